// File: rtl/prog_sweep_sched.sv
// prog_sweep_sched: write-verify sweep scheduler over BL/SL level, WL level and pulse width.
// Define SWEEP_ATTEMPT_CNT_EN to expose the saturating attempt counter as o_attempt_cnt.
module prog_sweep_sched #(
  parameter int BSL_BITS = 5,
  parameter int WL_BITS  = 8,
  parameter int PW_BITS  = 16,
  parameter int ATT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [ATT_BITS-1:0] i_max_attempts,
  input  logic [2:0]          i_loop_order,
  input  logic [BSL_BITS-1:0] i_bsl_start,
  input  logic [BSL_BITS-1:0] i_bsl_stop,
  input  logic [BSL_BITS-1:0] i_bsl_step,
  input  logic [WL_BITS-1:0]  i_wl_start,
  input  logic [WL_BITS-1:0]  i_wl_stop,
  input  logic [WL_BITS-1:0]  i_wl_step,
  input  logic [PW_BITS-1:0]  i_pw_start,
  input  logic [PW_BITS-1:0]  i_pw_stop,
  input  logic [PW_BITS-1:0]  i_pw_step,
  output logic                o_pulse_req,
  input  logic                i_pulse_done,
  output logic                o_verify_req,
  input  logic                i_verify_done,
  input  logic                i_verify_pass,
  output logic [BSL_BITS-1:0] o_bsl_lvl,
  output logic [WL_BITS-1:0]  o_wl_lvl,
  output logic [PW_BITS-1:0]  o_pw,
`ifdef SWEEP_ATTEMPT_CNT_EN
  output logic [ATT_BITS-1:0] o_attempt_cnt,
`endif
  output logic                o_busy,
  output logic                o_done,
  output logic                o_success
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PULSE, S_VERIFY, S_STEP, S_FINISH} state_t;
  state_t r_state, w_nxt;
  logic [ATT_BITS-1:0] r_max, r_att, w_att_inc;
  logic [2:0]          r_order;
  logic [BSL_BITS-1:0] r_bsl_start, r_bsl_stop, r_bsl_step, r_bsl, w_bsl_nxt;
  logic [WL_BITS-1:0]  r_wl_start, r_wl_stop, r_wl_step, r_wl, w_wl_nxt;
  logic [PW_BITS-1:0]  r_pw_start, r_pw_stop, r_pw_step, r_pw, w_pw_nxt;
  logic [BSL_BITS:0]   w_bsl_sum;
  logic [WL_BITS:0]    w_wl_sum;
  logic [PW_BITS:0]    w_pw_sum;
  logic [2:0]          w_wrap, w_adv;
  logic [1:0]          w_inner, w_mid, w_outer;
  logic                w_exh, w_lim, r_success;
  // Sums carry one extra bit so an overflowing step reads as "past stop" and wraps.
  assign w_bsl_sum = {1'b0, r_bsl} + {1'b0, r_bsl_step};
  assign w_wl_sum  = {1'b0, r_wl} + {1'b0, r_wl_step};
  assign w_pw_sum  = {1'b0, r_pw} + {1'b0, r_pw_step};
  assign w_wrap = {(r_pw_step == '0) || (w_pw_sum > {1'b0, r_pw_stop}),
                   (r_wl_step == '0) || (w_wl_sum > {1'b0, r_wl_stop}),
                   (r_bsl_step == '0) || (w_bsl_sum > {1'b0, r_bsl_stop})};
  // Axis index 0 = bsl, 1 = wl, 2 = pw.
  assign w_inner = (r_order == 3'd1 || r_order == 3'd4) ? 2'd1 :
                   (r_order == 3'd3 || r_order == 3'd5) ? 2'd2 : 2'd0;
  assign w_mid   = (r_order == 3'd1 || r_order == 3'd3) ? 2'd0 :
                   (r_order == 3'd2 || r_order == 3'd4) ? 2'd2 : 2'd1;
  assign w_outer = 2'd3 - w_inner - w_mid;
  always_comb begin
    w_adv = '0;
    w_adv[w_inner] = 1'b1;
    w_adv[w_mid] = w_wrap[w_inner];
    w_adv[w_outer] = w_wrap[w_inner] & w_wrap[w_mid];
  end
  assign w_exh     = &w_wrap;
  assign w_bsl_nxt = !w_adv[0] ? r_bsl : w_wrap[0] ? r_bsl_start : w_bsl_sum[BSL_BITS-1:0];
  assign w_wl_nxt  = !w_adv[1] ? r_wl : w_wrap[1] ? r_wl_start : w_wl_sum[WL_BITS-1:0];
  assign w_pw_nxt  = !w_adv[2] ? r_pw : w_wrap[2] ? r_pw_start : w_pw_sum[PW_BITS-1:0];
  assign w_lim     = (r_max != '0) && (r_att == r_max);
`ifdef SWEEP_ATTEMPT_CNT_EN
  assign w_att_inc     = (r_max == '0 && &r_att) ? r_att : r_att + 1'b1;
  assign o_attempt_cnt = r_att;
`else
  assign w_att_inc = r_att + 1'b1;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:   w_nxt = i_start ? S_LOAD : S_IDLE;
      S_LOAD:   w_nxt = S_PULSE;
      S_PULSE:  w_nxt = i_pulse_done ? S_VERIFY : S_PULSE;
      S_VERIFY: w_nxt = !i_verify_done ? S_VERIFY : (i_verify_pass || w_lim) ? S_FINISH : S_STEP;
      S_STEP:   w_nxt = w_exh ? S_FINISH : S_PULSE;
      default:  w_nxt = S_IDLE;
    endcase
    if (i_abort && r_state != S_IDLE && r_state != S_FINISH) w_nxt = S_FINISH;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_max       <= '0;
      r_order     <= '0;
      r_bsl_start <= '0;
      r_bsl_stop  <= '0;
      r_bsl_step  <= '0;
      r_wl_start  <= '0;
      r_wl_stop   <= '0;
      r_wl_step   <= '0;
      r_pw_start  <= '0;
      r_pw_stop   <= '0;
      r_pw_step   <= '0;
      r_bsl       <= '0;
      r_wl        <= '0;
      r_pw        <= '0;
      r_att       <= '0;
      r_success   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_LOAD) begin
        r_max       <= i_max_attempts;
        r_order     <= i_loop_order;
        r_bsl_start <= i_bsl_start;
        r_bsl_stop  <= i_bsl_stop;
        r_bsl_step  <= i_bsl_step;
        r_wl_start  <= i_wl_start;
        r_wl_stop   <= i_wl_stop;
        r_wl_step   <= i_wl_step;
        r_pw_start  <= i_pw_start;
        r_pw_stop   <= i_pw_stop;
        r_pw_step   <= i_pw_step;
        r_bsl       <= i_bsl_start;
        r_wl        <= i_wl_start;
        r_pw        <= i_pw_start;
        r_att       <= '0;
        r_success   <= 1'b0;
      end
      if (r_state == S_PULSE && i_pulse_done && !i_abort) r_att <= w_att_inc;
      if (r_state == S_STEP && !i_abort && !w_exh) begin
        r_bsl <= w_bsl_nxt;
        r_wl  <= w_wl_nxt;
        r_pw  <= w_pw_nxt;
      end
      if (r_state == S_VERIFY && i_verify_done && i_verify_pass && !i_abort) r_success <= 1'b1;
    end
  end
  assign o_pulse_req  = r_state == S_PULSE;
  assign o_verify_req = r_state == S_VERIFY;
  assign o_busy       = r_state != S_IDLE && r_state != S_FINISH;
  assign o_done       = r_state == S_FINISH;
  assign o_success    = r_success;
  assign o_bsl_lvl    = r_bsl;
  assign o_wl_lvl     = r_wl;
  assign o_pw         = r_pw;
endmodule

// File: tb/tb_prog_sweep_sched.sv
// tb_prog_sweep_sched: scoreboard bench; a point-list model predicts every pulse and each completion.
module tb_prog_sweep_sched;
  localparam int BB = 5, WB = 8, PB = 16, AB = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_start = 0, i_abort = 0, i_pulse_done = 0, i_verify_done = 0, i_verify_pass = 0;
  logic [AB-1:0] i_max_attempts = '0;
  logic [2:0] i_loop_order = '0;
  logic [BB-1:0] i_bsl_start = '0, i_bsl_stop = '0, i_bsl_step = '0;
  logic [WB-1:0] i_wl_start = '0, i_wl_stop = '0, i_wl_step = '0;
  logic [PB-1:0] i_pw_start = '0, i_pw_stop = '0, i_pw_step = '0;
  logic o_pulse_req, o_verify_req, o_busy, o_done, o_success;
  logic [BB-1:0] o_bsl_lvl;
  logic [WB-1:0] o_wl_lvl;
  logic [PB-1:0] o_pw;
`ifdef SWEEP_ATTEMPT_CNT_EN
  logic [AB-1:0] o_attempt_cnt;
`endif
  always #5 clk = ~clk;
  prog_sweep_sched dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_max_attempts(i_max_attempts), .i_loop_order(i_loop_order),
    .i_bsl_start(i_bsl_start), .i_bsl_stop(i_bsl_stop), .i_bsl_step(i_bsl_step),
    .i_wl_start(i_wl_start), .i_wl_stop(i_wl_stop), .i_wl_step(i_wl_step),
    .i_pw_start(i_pw_start), .i_pw_stop(i_pw_stop), .i_pw_step(i_pw_step),
    .o_pulse_req(o_pulse_req), .i_pulse_done(i_pulse_done),
    .o_verify_req(o_verify_req), .i_verify_done(i_verify_done), .i_verify_pass(i_verify_pass),
    .o_bsl_lvl(o_bsl_lvl), .o_wl_lvl(o_wl_lvl), .o_pw(o_pw),
`ifdef SWEEP_ATTEMPT_CNT_EN
    .o_attempt_cnt(o_attempt_cnt),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_success(o_success)
  );
  typedef struct { int b; int w; int p; } pt_t;
  typedef struct { bit s; int a; } dn_t;
  pt_t q_pulse[$];
  dn_t q_done[$];
  int n_chk = 0, n_pass = 0;
  int c_s[3], c_e[3], c_st[3], c_ord, c_max;
  int bits_tab[3] = '{BB, WB, PB};
  // Outer, middle, inner axis per loop_order (0 = bsl, 1 = wl, 2 = pw).
  int ord_tab[8][3] = '{'{2,1,0}, '{2,0,1}, '{1,2,0}, '{1,0,2}, '{0,2,1}, '{0,1,2}, '{2,1,0}, '{2,1,0}};
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic void model(input int pass_at, input int abort_at);
    int vals[3][64];
    int n[3];
    int v[3];
    int o, m, in, k, att;
    bit fin, succ;
    pt_t p;
    dn_t d;
    for (int a = 0; a < 3; a++) begin
      n[a] = 1;
      vals[a][0] = c_s[a];
      while (n[a] < 64 && c_st[a] != 0 && vals[a][n[a]-1] + c_st[a] <= c_e[a]
             && vals[a][n[a]-1] + c_st[a] < (1 << bits_tab[a])) begin
        vals[a][n[a]] = vals[a][n[a]-1] + c_st[a];
        n[a]++;
      end
    end
    o = ord_tab[c_ord][0]; m = ord_tab[c_ord][1]; in = ord_tab[c_ord][2];
    k = 0; att = 0; fin = 0; succ = 0;
    for (int x = 0; x < n[o]; x++)
      for (int y = 0; y < n[m]; y++)
        for (int z = 0; z < n[in]; z++)
          if (!fin) begin
            v[o] = vals[o][x]; v[m] = vals[m][y]; v[in] = vals[in][z];
            p.b = v[0]; p.w = v[1]; p.p = v[2];
            q_pulse.push_back(p);
            att++;
            if (k == abort_at) fin = 1;
            else if (k == pass_at) begin fin = 1; succ = 1; end
            else if (c_max != 0 && att == c_max) fin = 1;
            k++;
          end
    d.s = succ;
    d.a = (att > 255) ? 255 : att;
    q_done.push_back(d);
  endfunction
  task automatic cfg(input int bs, be, bp, ws, we, wp, ps, pe, pp, ord, mx);
    c_s[0] = bs; c_e[0] = be; c_st[0] = bp;
    c_s[1] = ws; c_e[1] = we; c_st[1] = wp;
    c_s[2] = ps; c_e[2] = pe; c_st[2] = pp;
    c_ord = ord; c_max = mx;
  endtask
  task automatic drive_cfg();
    i_bsl_start = BB'(c_s[0]); i_bsl_stop = BB'(c_e[0]); i_bsl_step = BB'(c_st[0]);
    i_wl_start = WB'(c_s[1]); i_wl_stop = WB'(c_e[1]); i_wl_step = WB'(c_st[1]);
    i_pw_start = PB'(c_s[2]); i_pw_stop = PB'(c_e[2]); i_pw_step = PB'(c_st[2]);
    i_loop_order = 3'(c_ord); i_max_attempts = AB'(c_max);
  endtask
  task automatic scramble();
    i_bsl_start = BB'($urandom); i_bsl_stop = BB'($urandom); i_bsl_step = BB'($urandom);
    i_wl_start = WB'($urandom); i_wl_stop = WB'($urandom); i_wl_step = WB'($urandom);
    i_pw_start = PB'($urandom); i_pw_stop = PB'($urandom); i_pw_step = PB'($urandom);
    i_loop_order = 3'($urandom); i_max_attempts = AB'($urandom);
  endtask
  task automatic sweep(input int pass_at, input int abort_at);
    int vc = 0, cyc = 0, d;
    model(pass_at, abort_at);
    drive_cfg();
    i_start = 1; @(negedge clk); i_start = 0; @(negedge clk);
    scramble();
    while (!o_done && cyc < 5000) begin
      if (o_pulse_req) begin
        d = $urandom_range(0, 2);
        repeat (d) begin i_start = ($urandom_range(0, 3) == 0); @(negedge clk); cyc++; end
        i_start = 0; i_pulse_done = 1; @(negedge clk); i_pulse_done = 0; cyc++;
      end else if (o_verify_req) begin
        d = $urandom_range(0, 2);
        repeat (d) begin @(negedge clk); cyc++; end
        i_verify_done = 1;
        i_verify_pass = (vc == pass_at) || (vc == abort_at);
        i_abort = (vc == abort_at);
        vc++;
        @(negedge clk); i_verify_done = 0; i_verify_pass = 0; i_abort = 0; cyc++;
      end else begin
        i_pulse_done = ($urandom_range(0, 7) == 0);
        @(negedge clk); i_pulse_done = 0; cyc++;
      end
    end
    chk("sweep_done_seen", o_done, 1);
    if (!o_done) begin
      rst_n = 0; @(negedge clk); rst_n = 1;
      q_pulse.delete(); q_done.delete();
    end
    @(negedge clk);
    chk("done_one_cycle", o_done, 0);
    chk("idle_not_busy", o_busy, 0);
  endtask
  pt_t ep, lastp;
  dn_t ed;
  bit prev_p = 0;
  always @(negedge clk) begin
    if (!rst_n) prev_p = 0;
    else begin
      if (o_pulse_req && !prev_p) begin
        chk("pulse_expected", q_pulse.size() > 0, 1);
        chk("busy_in_pulse", o_busy, 1);
        if (q_pulse.size() > 0) begin
          ep = q_pulse.pop_front();
          lastp = ep;
          chk("bsl_lvl", o_bsl_lvl, ep.b);
          chk("wl_lvl", o_wl_lvl, ep.w);
          chk("pw", o_pw, ep.p);
        end
      end
      if (o_verify_req) begin
        chk("bsl_stable_verify", o_bsl_lvl, lastp.b);
        chk("pw_stable_verify", o_pw, lastp.p);
      end
      if (o_done) begin
        chk("done_expected", q_done.size() > 0, 1);
        chk("busy_low_at_done", o_busy, 0);
        if (q_done.size() > 0) begin
          ed = q_done.pop_front();
          chk("success", o_success, ed.s);
          chk("pulses_left", q_pulse.size(), 0);
`ifdef SWEEP_ATTEMPT_CNT_EN
          chk("attempt_cnt", o_attempt_cnt, ed.a);
`endif
          q_pulse.delete();
        end
      end
      prev_p = o_pulse_req;
    end
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc, mv;
    repeat (3) @(negedge clk);
    chk("rst_pulse_req", o_pulse_req, 0);
    chk("rst_verify_req", o_verify_req, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_success", o_success, 0);
    chk("rst_bsl", o_bsl_lvl, 0);
    chk("rst_wl", o_wl_lvl, 0);
    chk("rst_pw", o_pw, 0);
    rst_n = 1; @(negedge clk);
    cfg(3, 3, 1, 10, 10, 1, 8, 8, 1, 0, 0); sweep(0, -1);
    chk("first_pass_success_held", o_success, 1);
    cfg(0, 2, 1, 5, 6, 1, 4, 4, 1, 0, 0); sweep(-1, -1);
    cfg(28, 31, 3, 0, 0, 1, 0, 0, 1, 0, 0); sweep(-1, -1);
    cfg(0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 3); sweep(-1, -1);
    cfg(20, 5, 1, 200, 100, 5, 9, 9, 0, 3, 0); sweep(-1, -1);
    cfg(0, 9, 1, 1, 1, 1, 2, 2, 1, 0, 0); sweep(-1, 1);
    repeat (5) begin @(negedge clk); chk("no_pulse_after_abort", o_pulse_req, 0); end
    cfg(0, 1, 1, 0, 2, 1, 100, 300, 100, 4, 0); sweep(-1, -1);
    cfg(0, 9, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    model(-1, -1); drive_cfg();
    i_start = 1; @(negedge clk); i_start = 0;
    cyc = 0;
    while (!o_pulse_req && cyc < 10) begin @(negedge clk); cyc++; end
    chk("pulse_before_reset", o_pulse_req, 1);
    rst_n = 0; @(negedge clk);
    chk("rst_mid_pulse_req", o_pulse_req, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_bsl", o_bsl_lvl, 0);
    rst_n = 1; q_pulse.delete(); q_done.delete();
    @(negedge clk);
    sweep(-1, -1);
    for (int t = 0; t < 40; t++) begin
      for (int a = 0; a < 3; a++) begin
        mv = (1 << bits_tab[a]) - 1;
        c_s[a] = (a == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(20, 31) : $urandom_range(0, mv);
        c_st[a] = $urandom_range(0, 5);
        c_e[a] = c_s[a] + c_st[a] * $urandom_range(0, 3) + $urandom_range(0, 1);
        if (c_e[a] > mv) c_e[a] = mv;
        if ($urandom_range(0, 7) == 0 && c_s[a] > 0) c_e[a] = c_s[a] - 1;
      end
      c_ord = $urandom_range(0, 7);
      c_max = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30);
      sweep(($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, 40), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1);
    end
    chk("pulse_queue_drained", q_pulse.size(), 0);
    chk("done_queue_drained", q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
